// File: rtl/soc_periph_hub.sv
// soc_periph_hub: memory-mapped peripheral block for the picorv32 native bus.
//
// Provides GPIO out/in (with set/clear/toggle aliases), an LED register, a UART TX
// hand-off, a buffered UART RX FIFO with RTS flow control and a free-running timer
// with a sticky compare match.
//
// Ports:
//   clk, rstn            system clock, asynchronous active-low reset
//   sel, addr, wdata,    CPU access (sel already qualified by the address window);
//   wstrb                wstrb != 0 is a write, wstrb == 0 a read
//   ready, rdata         access complete (one cycle after sel) and read data
//   gpio_out, gpio_in    output pins / asynchronous input pins
//   led                  LED enables
//   tx_start, tx_data,   byte hand-off to the external uart_tx core
//   tx_busy
//   rx_strobe, rx_byte   byte delivered by the external uart_rx core
//   uart_rts             1 = room to receive more bytes
//   timer_irq            level, mirrors the sticky timer match flag

module soc_periph_hub #(
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned NUM_LEDS   = 3,
  parameter int unsigned RX_DEPTH   = 16,
  parameter int unsigned RTS_MARGIN = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sel,
  input  logic [7:0]           addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  output logic                 ready,
  output logic [31:0]          rdata,
  output logic [OUT_WIDTH-1:0] gpio_out,
  input  logic [IN_WIDTH-1:0]  gpio_in,
  output logic [NUM_LEDS-1:0]  led,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 rx_strobe,
  input  logic [7:0]           rx_byte,
  output logic                 uart_rts,
  output logic                 timer_irq
);

  localparam int unsigned PtrW = $clog2(RX_DEPTH);
  localparam int unsigned CntW = $clog2(RX_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(RX_DEPTH);

  // Word offsets within the window
  localparam logic [5:0] OffOut    = 6'h00;
  localparam logic [5:0] OffIn     = 6'h01;
  localparam logic [5:0] OffLed    = 6'h02;
  localparam logic [5:0] OffSet    = 6'h03;
  localparam logic [5:0] OffUart   = 6'h04;
  localparam logic [5:0] OffStatus = 6'h05;
  localparam logic [5:0] OffClr    = 6'h06;
  localparam logic [5:0] OffTgl    = 6'h07;
  localparam logic [5:0] OffTimer  = 6'h08;
  localparam logic [5:0] OffCmp    = 6'h09;

  logic                 ready_q;
  logic [31:0]          rdata_q, rdata_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic [NUM_LEDS-1:0]  led_q, led_d;
  logic [IN_WIDTH-1:0]  in_meta_q, in_sync_q;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [31:0]          timer_q, timer_d;
  logic [31:0]          cmp_q, cmp_d;
  logic                 match_q, match_d;
  logic                 ovf_q, ovf_d;
  logic                 rts_q, rts_d;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [7:0]           fifo_mem [RX_DEPTH];

  logic        access, is_wr, is_rd;
  logic [5:0]  offset;
  logic [31:0] wmask, out_ext, led_ext, in_ext, merged_out, merged_led;
  logic        pop, push, full, nonempty, ovf_set, ovf_clr, match_clr;
  logic [8:0]  cnt_ext;
  logic [7:0]  cnt_sat;
  logic [31:0] free_d;
  logic        unused_addr;

  assign unused_addr = ^addr[1:0];

  always_comb begin
    access = sel & ~ready_q;
    is_wr  = access & (wstrb != 4'b0);
    is_rd  = access & (wstrb == 4'b0);
    offset = addr[7:2];
    wmask  = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};

    out_ext = '0;
    out_ext[OUT_WIDTH-1:0] = out_q;
    led_ext = '0;
    led_ext[NUM_LEDS-1:0] = led_q;
    in_ext = '0;
    in_ext[IN_WIDTH-1:0] = in_sync_q;
    merged_out = (out_ext & ~wmask) | (wdata & wmask);
    merged_led = (led_ext & ~wmask) | (wdata & wmask);

    full     = (count_q == CntFull);
    nonempty = (count_q != '0);
    cnt_ext  = 9'(count_q);
    cnt_sat  = (cnt_ext > 9'd255) ? 8'hFF : cnt_ext[7:0];

    out_d      = out_q;
    led_d      = led_q;
    cmp_d      = cmp_q;
    timer_d    = timer_q + 32'd1;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    rdata_d    = '0;
    pop        = 1'b0;
    ovf_clr    = 1'b0;
    match_clr  = 1'b0;

    if (is_wr) begin
      case (offset)
        OffOut:    out_d = merged_out[OUT_WIDTH-1:0];
        OffLed:    led_d = merged_led[NUM_LEDS-1:0];
        OffSet:    out_d = out_q | wdata[OUT_WIDTH-1:0];
        OffClr:    out_d = out_q & ~wdata[OUT_WIDTH-1:0];
        OffTgl:    out_d = out_q ^ wdata[OUT_WIDTH-1:0];
        OffUart: begin
          // A write while the transmitter is busy is dropped, not queued
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = wdata[7:0];
          end
        end
        OffStatus: begin
          ovf_clr   = wdata[3];
          match_clr = wdata[4];
        end
        OffTimer:  timer_d = (timer_q & ~wmask) | (wdata & wmask);
        OffCmp:    cmp_d   = (cmp_q & ~wmask) | (wdata & wmask);
        default: ;
      endcase
    end

    if (is_rd) begin
      case (offset)
        OffOut:    rdata_d = out_ext;
        OffIn:     rdata_d = in_ext;
        OffLed:    rdata_d = led_ext;
        OffUart: begin
          if (nonempty) begin
            rdata_d = {23'b0, 1'b1, fifo_mem[rd_ptr_q]};
            pop     = 1'b1;
          end
        end
        OffStatus: rdata_d = {16'b0, cnt_sat, 3'b0, match_q, ovf_q, full, nonempty, tx_busy};
        OffTimer:  rdata_d = timer_q;
        OffCmp:    rdata_d = cmp_q;
        default: ;
      endcase
    end

    // A same-cycle pop frees the slot, so a strobe into a full FIFO still lands
    push    = rx_strobe & (~full | pop);
    ovf_set = rx_strobe & full & ~pop;

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    free_d  = 32'(RX_DEPTH) - 32'(count_d);
    rts_d   = free_d > 32'(RTS_MARGIN);
    ovf_d   = ovf_set | (ovf_q & ~ovf_clr);
    // Compare against the post-increment/post-load timer; set wins over clear
    match_d = (timer_d == cmp_q) | (match_q & ~match_clr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      out_q      <= '0;
      led_q      <= '0;
      in_meta_q  <= '0;
      in_sync_q  <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      timer_q    <= '0;
      cmp_q      <= 32'hFFFF_FFFF;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
      rts_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      ready_q    <= access;
      rdata_q    <= rdata_d;
      out_q      <= out_d;
      led_q      <= led_d;
      in_meta_q  <= gpio_in;
      in_sync_q  <= in_meta_q;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
      rts_q      <= rts_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rx_byte;
  end

  assign ready     = ready_q;
  assign rdata     = rdata_q;
  assign gpio_out  = out_q;
  assign led       = led_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign uart_rts  = rts_q;
  assign timer_irq = match_q;

endmodule

// File: tb/tb_soc_periph_hub.sv
// Self-checking bench for soc_periph_hub: directed bus/UART/timer stimulus, a
// behavioural register/FIFO model compared every cycle, plus literal expectations.

module tb_soc_periph_hub;

  localparam int unsigned Depth  = 16;
  localparam int unsigned Margin = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        sel = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        ready;
  logic [31:0] rdata;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_in = '0;
  logic [2:0]  led;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        rx_strobe = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        uart_rts;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  soc_periph_hub #(
    .OUT_WIDTH (8),
    .IN_WIDTH  (8),
    .NUM_LEDS  (3),
    .RX_DEPTH  (Depth),
    .RTS_MARGIN(Margin)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .sel      (sel),
    .addr     (addr),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .ready    (ready),
    .rdata    (rdata),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in),
    .led      (led),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .rx_strobe(rx_strobe),
    .rx_byte  (rx_byte),
    .uart_rts (uart_rts),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_out, m_led, m_timer, m_cmp, m_rdata;
  logic [7:0]  m_tx_data, m_in1, m_in2;
  logic        m_ready, m_tx_start, m_ovf, m_match, m_rts;
  logic [7:0]  m_q [$];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic model_step();
    logic        acc, wr, rd, tx_go, ovf_set, ovf_clr, match_clr;
    logic [5:0]  off;
    logic [31:0] t_next, cmp_old, rv;
    int          n;
    acc = sel && !m_ready;
    wr  = acc && (wstrb != 4'b0);
    rd  = acc && (wstrb == 4'b0);
    off = addr[7:2];
    t_next = m_timer + 32'd1;
    cmp_old = m_cmp;
    rv = '0; tx_go = 1'b0; ovf_set = 1'b0; ovf_clr = 1'b0; match_clr = 1'b0;
    n = m_q.size();
    if (wr) begin
      case (off)
        6'd0: m_out = merge(m_out, wdata, wstrb) & 32'hFF;
        6'd2: m_led = merge(m_led, wdata, wstrb) & 32'h7;
        6'd3: m_out = (m_out | wdata) & 32'hFF;
        6'd6: m_out = m_out & ~wdata & 32'hFF;
        6'd7: m_out = (m_out ^ wdata) & 32'hFF;
        6'd4: if (!tx_busy) begin tx_go = 1'b1; m_tx_data = wdata[7:0]; end
        6'd5: begin ovf_clr = wdata[3]; match_clr = wdata[4]; end
        6'd8: t_next = merge(m_timer, wdata, wstrb);
        6'd9: m_cmp = merge(m_cmp, wdata, wstrb);
        default: ;
      endcase
    end
    if (rd) begin
      case (off)
        6'd0: rv = m_out;
        6'd1: rv = 32'(m_in2);
        6'd2: rv = m_led;
        6'd4: if (n > 0) rv = 32'h100 | 32'(m_q.pop_front());
        6'd5: rv = 32'(tx_busy) | ((n != 0) ? 32'h2 : 32'h0) | ((n == Depth) ? 32'h4 : 32'h0)
                 | (m_ovf ? 32'h8 : 32'h0) | (m_match ? 32'h10 : 32'h0)
                 | (32'((n > 255) ? 255 : n) << 8);
        6'd8: rv = m_timer;
        6'd9: rv = m_cmp;
        default: ;
      endcase
    end
    if (rx_strobe) begin
      if (m_q.size() < Depth) m_q.push_back(rx_byte);
      else ovf_set = 1'b1;
    end
    m_ovf      = ovf_set || (m_ovf && !ovf_clr);
    m_match    = (t_next == cmp_old) || (m_match && !match_clr);
    m_timer    = t_next;
    m_ready    = acc;
    m_rdata    = acc ? rv : 32'h0;
    m_tx_start = tx_go;
    m_rts      = (Depth - m_q.size()) > Margin;
    m_in2      = m_in1;
    m_in1      = gpio_in;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rstn) begin
        m_out = '0; m_led = '0; m_timer = '0; m_cmp = 32'hFFFF_FFFF; m_rdata = '0;
        m_tx_data = '0; m_in1 = '0; m_in2 = '0; m_ready = 1'b0; m_tx_start = 1'b0;
        m_ovf = 1'b0; m_match = 1'b0; m_rts = 1'b1;
        m_q.delete();
      end else begin
        model_step();
      end
      check("ready", 32'(ready), 32'(m_ready));
      check("rdata", rdata, m_rdata);
      check("gpio_out", 32'(gpio_out), m_out);
      check("led", 32'(led), m_led);
      check("tx_start", 32'(tx_start), 32'(m_tx_start));
      check("tx_data", 32'(tx_data), 32'(m_tx_data));
      check("uart_rts", 32'(uart_rts), 32'(m_rts));
      check("timer_irq", 32'(timer_irq), 32'(m_match));
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic rx, input logic [7:0] rb, output logic [31:0] r);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; wstrb = s; rx_strobe = rx; rx_byte = rb;
    @(negedge clk);
    check("bus_ready", 32'(ready), 32'h1);
    r = rdata;
    sel = 1'b0; wstrb = 4'b0; rx_strobe = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    bus(a, d, s, 1'b0, 8'h00, r);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] r;
    bus(a, 32'h0, 4'b0, 1'b0, 8'h00, r);
    check(nm, r, exp);
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk);
    rx_strobe = 1'b1; rx_byte = b;
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] r;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    gpio_in = 8'h3C;

    // Reset values
    check("rts_after_reset", 32'(uart_rts), 32'h1);
    rd(8'h00, 32'h0, "out_reset");
    rd(8'h08, 32'h0, "led_reset");
    rd(8'h14, 32'h0, "status_reset");
    rd(8'h24, 32'hFFFF_FFFF, "cmp_reset");

    // GPIO output aliases
    wr(8'h00, 32'hA5, 4'hF);
    rd(8'h00, 32'hA5, "out_write");
    wr(8'h0C, 32'h0F, 4'hF);
    rd(8'h00, 32'hAF, "out_set");
    wr(8'h18, 32'h81, 4'hF);
    rd(8'h00, 32'h2E, "out_clr");
    wr(8'h1C, 32'hFF, 4'hF);
    rd(8'h00, 32'hD1, "out_tgl");
    check("gpio_pins", 32'(gpio_out), 32'hD1);
    wr(8'h00, 32'h0000_FF00, 4'b0010);
    rd(8'h00, 32'hD1, "out_lane_masked");
    rd(8'h03, 32'hD1, "addr_low_bits_ignored");
    rd(8'h0C, 32'h0, "set_reads_zero");
    wr(8'h28, 32'hFFFF_FFFF, 4'hF);
    rd(8'h28, 32'h0, "undef_read");
    rd(8'h00, 32'hD1, "undef_write_ignored");

    // LED, IN, CMP byte lanes
    wr(8'h08, 32'hFFFF_FFFF, 4'hF);
    rd(8'h08, 32'h7, "led_width");
    check("led_pins", 32'(led), 32'h7);
    rd(8'h04, 32'h3C, "gpio_in_sync");
    wr(8'h24, 32'h1234_5678, 4'b0011);
    rd(8'h24, 32'hFFFF_5678, "cmp_lane_write");

    // UART TX
    wr(8'h10, 32'h41, 4'hF);
    check("tx_pulse", 32'(tx_start), 32'h1);
    check("tx_byte", 32'(tx_data), 32'h41);
    @(negedge clk);
    check("tx_pulse_one_cycle", 32'(tx_start), 32'h0);
    tx_busy = 1'b1;
    wr(8'h10, 32'h42, 4'hF);
    check("tx_dropped_when_busy", 32'(tx_start), 32'h0);
    rd(8'h14, 32'h1, "status_tx_busy");
    tx_busy = 1'b0;

    // RX FIFO overflow and RTS threshold
    for (int i = 0; i < 17; i++) begin
      rx_push(8'(i));
      check("rts_level", 32'(uart_rts), (i + 1 < 12) ? 32'h1 : 32'h0);
    end
    rd(8'h14, 32'h0000_100E, "status_full_ovf");
    for (int i = 0; i < 16; i++) rd(8'h10, 32'h100 + 32'(i), "rx_pop_order");
    rd(8'h10, 32'h0, "rx_empty_read");
    wr(8'h14, 32'h08, 4'hF);
    rd(8'h14, 32'h0, "ovf_cleared");

    // Push into a full FIFO on the same cycle as a pop
    for (int i = 0; i < 16; i++) rx_push(8'h20 + 8'(i));
    bus(8'h10, 32'h0, 4'b0, 1'b1, 8'h55, r);
    check("pop_with_push_head", r, 32'h120);
    rd(8'h14, 32'h0000_1006, "full_pop_push_status");
    for (int i = 1; i < 16; i++) rd(8'h10, 32'h120 + 32'(i), "rx_pop_order2");
    rd(8'h10, 32'h155, "pushed_byte_last");
    rd(8'h10, 32'h0, "rx_empty_read2");

    // Timer compare and wrap
    wr(8'h24, 32'd100, 4'hF);
    wr(8'h20, 32'd90, 4'hF);
    check("irq_before_match", 32'(timer_irq), 32'h0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9)  check("irq_not_yet", 32'(timer_irq), 32'h0);
      if (k == 10) check("irq_at_match", 32'(timer_irq), 32'h1);
    end
    rd(8'h14, 32'h10, "status_match");
    wr(8'h14, 32'h10, 4'hF);
    check("irq_cleared", 32'(timer_irq), 32'h0);
    rd(8'h14, 32'h0, "status_match_cleared");
    wr(8'h20, 32'hFFFF_FFFE, 4'hF);
    rd(8'h20, 32'hFFFF_FFFF, "timer_before_wrap");
    rd(8'h20, 32'h1, "timer_after_wrap");

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
